// File: rtl/divisor_frecuencia_programable_if.sv
// Select/enable inputs and wave/status outputs of the programmable frequency divider.
interface divisor_frecuencia_programable_if #(
  parameter int N = 3
);
  logic         en;
  logic [N-1:0] sel;
  logic         clk_out;
  logic         tick;
  logic [N-1:0] sel_act;
  logic         busy;

  modport master (output en, sel, input clk_out, tick, sel_act, busy);
  modport slave  (input en, sel, output clk_out, tick, sel_act, busy);
endinterface

// File: rtl/divisor_frecuencia_programable.sv
// Programmable square-wave divider: half-period = HALF_BASE >> sel_act, select applied only at
// half-period boundaries, with an enable that drains to a clean low level before stopping.
module divisor_frecuencia_programable #(
  parameter int N         = 3,
  parameter int HALF_BASE = 25_000_000,
  parameter int CW        = 25
) (
  input  logic clk,
  input  logic reset,
  divisor_frecuencia_programable_if.slave bus
);
  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DRAIN} state_t;

  localparam logic [CW-1:0] HB = CW'(HALF_BASE);

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx, w_hp;
  logic          r_clk_out, w_clk_out_nx;
  logic          r_tick, w_tick_nx;
  logic [N-1:0]  r_sel_act, w_sel_act_nx;
  logic          w_bnd;

  assign w_hp  = HB >> r_sel_act;
  assign w_bnd = (r_cnt == w_hp - CW'(1));

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_clk_out_nx = r_clk_out;
    w_sel_act_nx = r_sel_act;
    w_tick_nx    = 1'b0;
    case (r_state)
      ST_STOP: begin
        w_cnt_nx     = '0;
        w_clk_out_nx = 1'b0;
        if (bus.en) begin
          w_state_nx   = ST_RUN;
          w_clk_out_nx = 1'b1;
          w_tick_nx    = 1'b1;
          w_sel_act_nx = bus.sel;
        end
      end
      ST_RUN: begin
        if (w_bnd) begin
          w_cnt_nx     = '0;
          w_clk_out_nx = ~r_clk_out;
          w_tick_nx    = ~r_clk_out;
          w_sel_act_nx = bus.sel;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
        // a boundary coinciding with en=0 still toggles; the drain starts afterwards
        if (!bus.en) w_state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_bnd) begin
          w_cnt_nx     = '0;
          w_clk_out_nx = 1'b0;
          w_state_nx   = ST_STOP;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
          if (bus.en) w_state_nx = ST_RUN;
        end
      end
      default: begin
        w_state_nx   = ST_STOP;
        w_cnt_nx     = '0;
        w_clk_out_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_STOP;
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
      r_sel_act <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_clk_out <= w_clk_out_nx;
      r_tick    <= w_tick_nx;
      r_sel_act <= w_sel_act_nx;
    end
  end

  assign bus.clk_out = r_clk_out;
  assign bus.tick    = r_tick;
  assign bus.sel_act = r_sel_act;
  assign bus.busy    = (r_state != ST_STOP);
endmodule

// File: tb/tb_divisor_frecuencia_programable.sv
// Directed + random bench for the programmable divider against a countdown-per-phase model.
module tb_divisor_frecuencia_programable;
  localparam int N  = 3;
  localparam int HB = 128;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  divisor_frecuencia_programable_if #(.N(N)) bus ();

  divisor_frecuencia_programable #(.N(N), .HALF_BASE(HB), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: each phase is a countdown of HB>>sel cycles; the wave flips when it expires.
  bit         m_busy, m_drain, m_level, m_tick;
  int         m_left;
  logic [N-1:0] m_sel;

  function automatic int hp_of(input logic [N-1:0] s);
    return HB / (1 << s);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_drain = 0; m_level = 0; m_tick = 0; m_left = 0; m_sel = '0;
  endtask

  task automatic model_step(input bit en, input logic [N-1:0] s);
    bit expire;
    m_tick = 0;
    if (!m_busy) begin
      if (en) begin
        m_busy = 1; m_drain = 0; m_level = 1; m_tick = 1; m_sel = s; m_left = hp_of(s);
      end
    end else begin
      expire = (m_left == 1);
      m_left = m_left - 1;
      if (!m_drain) begin
        if (expire) begin
          m_level = !m_level; m_tick = m_level; m_sel = s; m_left = hp_of(s);
        end
        m_drain = !en;
      end else if (expire) begin
        m_level = 0; m_busy = 0; m_drain = 0;
      end else if (en) begin
        m_drain = 0;
      end
    end
  endtask

  function automatic logic [N+2:0] obs();
    return {bus.busy, bus.tick, bus.clk_out, bus.sel_act};
  endfunction

  function automatic logic [N+2:0] expv();
    return {logic'(m_busy), logic'(m_tick), logic'(m_level), m_sel};
  endfunction

  task automatic chk(input string tag, input logic [N+2:0] o, input logic [N+2:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (busy,tick,clk_out,sel_act)", tag, o, e);
    end
  endtask

  task automatic chk1(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // One clock edge: inputs already stable, model advances, outputs sampled on the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_step(bus.en, bus.sel);
    @(negedge clk);
    chk(tag, obs(), expv());
  endtask

  task automatic drain_to_stop();
    int n;
    bus.en = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 400) begin
      step("drain");
      n++;
    end
    chk1("drain_bound", int'(bus.busy === 1'b1), 0);
  endtask

  initial begin
    int ticks;
    model_reset();
    bus.en = 1'b0;
    bus.sel = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", obs(), '0);
    reset = 1'b0;

    // 1: idle with en low
    for (int i = 0; i < 20; i++) step("idle");

    // 2: sel=0, tick every 256 cycles starting one edge after enable
    bus.sel = 3'd0; bus.en = 1'b1;
    ticks = 0;
    for (int i = 1; i <= 520; i++) begin
      step("sel0");
      if (i == 1) chk1("sel0_first_tick", int'(bus.tick), 1);
      if (i == 128) chk1("sel0_high128", int'(bus.clk_out), 1);
      if (i == 129) chk1("sel0_low_at129", int'(bus.clk_out), 0);
      if (bus.tick === 1'b1) ticks++;
    end
    chk1("sel0_tick_count", ticks, 3);
    drain_to_stop();

    // 3: sel=7, period 2
    bus.sel = 3'd7; bus.en = 1'b1;
    ticks = 0;
    for (int i = 1; i <= 20; i++) begin
      step("sel7");
      chk1("sel7_toggle", int'(bus.clk_out), i % 2);
      if (bus.tick === 1'b1) ticks++;
    end
    chk1("sel7_tick_count", ticks, 10);
    drain_to_stop();

    // 4: sel 2 -> 3 mid high phase
    bus.sel = 3'd2; bus.en = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step("selchg");
      if (i == 11) bus.sel = 3'd3;
      if (i == 32) chk1("selchg_high32", int'(bus.clk_out), 1);
      if (i == 33) chk("selchg_fall", obs(), {1'b1, 1'b0, 1'b0, 3'd3});
      if (i == 48) chk1("selchg_low16", int'(bus.clk_out), 0);
      if (i == 49) chk("selchg_rise", obs(), {1'b1, 1'b1, 1'b1, 3'd3});
    end
    drain_to_stop();

    // 5a: drop en mid high phase, drain to low
    bus.sel = 3'd1; bus.en = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      step("drain_a");
      if (i == 20) bus.en = 1'b0;
      if (i == 64) chk("drain_a_high", obs(), {1'b1, 1'b0, 1'b1, 3'd1});
      if (i == 65) chk("drain_a_stop", obs(), {1'b0, 1'b0, 1'b0, 3'd1});
    end
    // 5b: re-raise en during drain
    bus.en = 1'b1;
    for (int i = 1; i <= 140; i++) begin
      step("drain_b");
      if (i == 20) bus.en = 1'b0;
      if (i == 30) bus.en = 1'b1;
      if (i == 65) chk("drain_b_fall", obs(), {1'b1, 1'b0, 1'b0, 3'd1});
      if (i == 129) chk("drain_b_rise", obs(), {1'b1, 1'b1, 1'b1, 3'd1});
    end

    // 6: async reset mid high phase
    bus.sel = 3'd2;
    @(posedge clk);
    model_step(bus.en, bus.sel);
    #2 reset = 1'b1;
    #1 chk("async_reset", obs(), '0);
    model_reset();
    @(negedge clk);
    chk("reset_hold", obs(), '0);
    reset = 1'b0;
    bus.en = 1'b1; bus.sel = 3'd4;
    step("restart");
    chk1("restart_tick", int'(bus.tick), 1);
    for (int i = 0; i < 30; i++) step("restart_run");

    // random en/sel traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bus.sel = N'($urandom);
      step("random");
    end
    drain_to_stop();
    for (int i = 0; i < 10; i++) step("final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
